ps2_rx_decoder: RTL and testbench

Upstream feeder for the seven-segment scancode display. Receives PS/2 keyboard frames on the raw PS/2 clock/data pins and deframes them into bytes. Checks start, parity and stop bits. Tracks make/break sequences and presents the last pressed key as `scancode` plus a key-held `flag`, which the display consumes directly.

---
 rtl/ps2_rx_decoder.sv | 220 ++++++++++++++++++++++
 tb/tb_ps2_rx_decoder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_decoder.sv
// PS/2 keyboard receiver: conditions the raw PS/2 clock/data pins, deframes
// 11-bit frames (start, 8 data LSB first, odd parity, stop) into bytes, and
// tracks make/break/extended sequences to present the last pressed key.
module ps2_rx_decoder #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 200000
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       PS2Clk,
    input  logic       PS2Data,
    output logic [7:0] scancode,
    output logic       flag,
    output logic [7:0] rx_byte,
    output logic       valid,
    output logic       err
);

    localparam int unsigned FW = (FILTER_LEN < 2) ? 1 : $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

    typedef enum logic [1:0] {
        F_IDLE,
        F_DATA,
        F_PARITY,
        F_STOP
    } frame_state_t;

    typedef enum logic {
        D_MAKE,
        D_BREAK
    } dec_state_t;

    // Input synchronizers (idle high)
    logic          clk_s1_q, clk_s2_q;
    logic          dat_s1_q, dat_s2_q;

    // Clock glitch filter
    logic          filt_q, filt_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          sample_evt;

    // Frame FSM
    frame_state_t  fstate_q, fstate_d;
    logic [2:0]    bcnt_q, bcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          par_q, par_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [7:0]    rx_q, rx_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    // Decoder FSM
    dec_state_t    dstate_q, dstate_d;
    logic          ext_q, ext_d;
    logic [7:0]    sc_q, sc_d;
    logic          flag_q, flag_d;

    // Two-flop synchronizers for both PS/2 pins
    always_ff @(posedge CLK) begin
        if (RST) begin
            clk_s1_q <= 1'b1;
            clk_s2_q <= 1'b1;
            dat_s1_q <= 1'b1;
            dat_s2_q <= 1'b1;
        end else begin
            clk_s1_q <= PS2Clk;
            clk_s2_q <= clk_s1_q;
            dat_s1_q <= PS2Data;
            dat_s2_q <= dat_s1_q;
        end
    end

    // Filtered clock flips only after FILTER_LEN consecutive differing samples
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (clk_s2_q != filt_q) begin
            if (fcnt_q == FW'(FILTER_LEN - 1)) begin
                filt_d = ~filt_q;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
    end

    // Sample event: the filtered clock is about to go 1 -> 0 this cycle
    assign sample_evt = filt_q & ~filt_d;

    // Filter state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end

    // Frame FSM next state, timeout handling and registered valid/err pulses
    always_comb begin
        fstate_d = fstate_q;
        bcnt_d   = bcnt_q;
        shift_d  = shift_q;
        par_d    = par_q;
        tcnt_d   = '0;
        rx_d     = rx_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;

        if (fstate_q != F_IDLE && tcnt_q == TW'(TIMEOUT - 1)) begin
            // Timeout wins over a coincident sample event
            fstate_d = F_IDLE;
            err_d    = 1'b1;
        end else if (sample_evt) begin
            unique case (fstate_q)
                F_IDLE: begin
                    if (!dat_s2_q) begin
                        fstate_d = F_DATA;
                        bcnt_d   = '0;
                    end
                end
                F_DATA: begin
                    shift_d = {dat_s2_q, shift_q[7:1]};
                    bcnt_d  = bcnt_q + 3'd1;
                    if (bcnt_q == 3'd7) begin
                        fstate_d = F_PARITY;
                    end
                end
                F_PARITY: begin
                    par_d    = dat_s2_q;
                    fstate_d = F_STOP;
                end
                F_STOP: begin
                    if ((^{shift_q, par_q}) && dat_s2_q) begin
                        rx_d    = shift_q;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                    fstate_d = F_IDLE;
                end
                default: fstate_d = F_IDLE;
            endcase
        end else if (fstate_q != F_IDLE) begin
            tcnt_d = tcnt_q + 1'b1;
        end
    end

    // Frame FSM state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            fstate_q <= F_IDLE;
            bcnt_q   <= '0;
            shift_q  <= '0;
            par_q    <= 1'b0;
            tcnt_q   <= '0;
            rx_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            fstate_q <= fstate_d;
            bcnt_q   <= bcnt_d;
            shift_q  <= shift_d;
            par_q    <= par_d;
            tcnt_q   <= tcnt_d;
            rx_q     <= rx_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
        end
    end

    // Make/break decoder acting on each received byte
    always_comb begin
        dstate_d = dstate_q;
        ext_d    = ext_q;
        sc_d     = sc_q;
        flag_d   = flag_q;
        if (valid_q) begin
            if (rx_q == 8'hE0) begin
                ext_d = 1'b1;
            end else if (rx_q == 8'hF0) begin
                dstate_d = D_BREAK;
            end else if (dstate_q == D_MAKE) begin
                sc_d   = rx_q;
                flag_d = 1'b1;
                ext_d  = 1'b0;
            end else begin
                if (rx_q == sc_q) begin
                    flag_d = 1'b0;
                end
                dstate_d = D_MAKE;
                ext_d    = 1'b0;
            end
        end
    end

    // Decoder state register
    always_ff @(posedge CLK) begin
        if (RST) begin
            dstate_q <= D_MAKE;
            ext_q    <= 1'b0;
            sc_q     <= '0;
            flag_q   <= 1'b0;
        end else begin
            dstate_q <= dstate_d;
            ext_q    <= ext_d;
            sc_q     <= sc_d;
            flag_q   <= flag_d;
        end
    end

    assign scancode = sc_q;
    assign flag     = flag_q;
    assign rx_byte  = rx_q;
    assign valid    = valid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ps2_rx_decoder.sv
// Directed + randomized bench for ps2_rx_decoder with a byte-level key model.
module tb_ps2_rx_decoder;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       PS2Clk = 1'b1;
    logic       PS2Data = 1'b1;
    logic [7:0] scancode;
    logic       flag;
    logic [7:0] rx_byte;
    logic       valid;
    logic       err;

    int unsigned checks = 0;
    int unsigned failures = 0;

    // Monitor state
    int unsigned valid_cnt = 0;
    int unsigned err_cnt = 0;
    int unsigned both_cnt = 0;
    logic        valid_prev = 1'b0;
    logic [7:0]  snap_sc = '0;
    logic        snap_flag = 1'b0;

    // Reference model
    logic [7:0]  m_rx = '0;
    logic [7:0]  m_sc = '0;
    logic        m_flag = 1'b0;
    bit          m_brk = 1'b0;

    int unsigned v0, e0;

    ps2_rx_decoder #(.FILTER_LEN(4), .TIMEOUT(2000)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .PS2Clk   (PS2Clk),
        .PS2Data  (PS2Data),
        .scancode (scancode),
        .flag     (flag),
        .rx_byte  (rx_byte),
        .valid    (valid),
        .err      (err)
    );

    always #5 CLK = ~CLK;

    // Count pulses; snapshot key outputs one cycle after each valid pulse
    always @(negedge CLK) begin
        if (valid) valid_cnt++;
        if (err) err_cnt++;
        if (valid && err) both_cnt++;
        if (valid_prev) begin
            snap_sc   = scancode;
            snap_flag = flag;
        end
        valid_prev = valid;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Odd parity bit that makes data+parity have an odd number of ones
    function automatic logic odd_par(input logic [7:0] b);
        int unsigned ones = 0;
        for (int unsigned i = 0; i < 8; i++) ones += b[i];
        return (ones % 2 == 0) ? 1'b1 : 1'b0;
    endfunction

    // Drive up to 11 bits of a frame, 40 CLK per bit (20 high, 20 low)
    task automatic send_frame(input logic [7:0] b, input bit bad_par, input logic stop,
                              input int unsigned nbits);
        logic [10:0] bits;
        bits = {stop, odd_par(b) ^ bad_par, b, 1'b0};
        for (int unsigned i = 0; i < nbits; i++) begin
            PS2Data = bits[i];
            cyc(10);
            PS2Clk = 1'b0;
            cyc(20);
            PS2Clk = 1'b1;
            cyc(10);
        end
        PS2Data = 1'b1;
        cyc(10);
    endtask

    // Byte-level key tracking from the make/break rules
    task automatic model_byte(input logic [7:0] b);
        m_rx = b;
        if (b == 8'hE0) begin
        end else if (b == 8'hF0) begin
            m_brk = 1'b1;
        end else if (!m_brk) begin
            m_sc   = b;
            m_flag = 1'b1;
        end else begin
            if (b == m_sc) m_flag = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic good_frame(input string tag, input logic [7:0] b);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(b, 1'b0, 1'b1, 11);
        model_byte(b);
        @(negedge CLK);
        chk({tag, "_valid"}, valid_cnt - v0, 1);
        chk({tag, "_err"}, err_cnt - e0, 0);
        chk({tag, "_rx"}, rx_byte, m_rx);
        chk({tag, "_sc"}, scancode, m_sc);
        chk({tag, "_flag"}, flag, m_flag);
        chk({tag, "_lat_sc"}, snap_sc, m_sc);
        chk({tag, "_lat_flag"}, snap_flag, m_flag);
    endtask

    task automatic bad_frame(input string tag, input logic [7:0] b, input bit bad_par,
                             input logic stop);
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(b, bad_par, stop, 11);
        @(negedge CLK);
        chk({tag, "_valid"}, valid_cnt - v0, 0);
        chk({tag, "_err"}, err_cnt - e0, 1);
        chk({tag, "_rx"}, rx_byte, m_rx);
        chk({tag, "_sc"}, scancode, m_sc);
        chk({tag, "_flag"}, flag, m_flag);
    endtask

    initial begin
        logic [7:0] rb;
        int unsigned sel;

        // Reset state
        cyc(5);
        @(negedge CLK);
        chk("rst_sc", scancode, 0);
        chk("rst_flag", flag, 0);
        chk("rst_rx", rx_byte, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        RST = 1'b0;
        cyc(20);

        // 1. Single key press
        good_frame("press1c", 8'h1C);

        // 2. Key release, then release of a different key
        good_frame("brk_f0", 8'hF0);
        good_frame("brk_1c", 8'h1C);
        chk("release_flag", flag, 0);
        good_frame("press1c_b", 8'h1C);
        good_frame("brk2_f0", 8'hF0);
        good_frame("brk2_1b", 8'h1B);
        chk("other_release_flag", flag, 1);
        chk("other_release_sc", scancode, 8'h1C);

        // 3. Framing errors: bad parity, then bad stop bit
        bad_frame("bad_par", 8'h1D, 1'b1, 1'b1);
        bad_frame("bad_stop", 8'h2A, 1'b0, 1'b0);

        // 4. Timeout mid-frame, then recovery
        v0 = valid_cnt;
        e0 = err_cnt;
        send_frame(8'h55, 1'b0, 1'b1, 5);
        cyc(2100);
        @(negedge CLK);
        chk("timeout_err", err_cnt - e0, 1);
        chk("timeout_valid", valid_cnt - v0, 0);
        good_frame("after_to", 8'h75);

        // 5. Short clock glitch while idle with data low
        v0 = valid_cnt;
        e0 = err_cnt;
        PS2Data = 1'b0;
        cyc(5);
        PS2Clk = 1'b0;
        cyc(2);
        PS2Clk = 1'b1;
        cyc(5);
        PS2Data = 1'b1;
        cyc(40);
        @(negedge CLK);
        chk("glitch_valid", valid_cnt - v0, 0);
        chk("glitch_err", err_cnt - e0, 0);
        good_frame("post_glitch", 8'h29);

        // 6. Extended code, then reset mid-frame
        good_frame("ext_e0", 8'hE0);
        good_frame("ext_75", 8'h75);
        chk("ext_sc", scancode, 8'h75);
        chk("ext_flag", flag, 1);
        send_frame(8'h4B, 1'b0, 1'b1, 5);
        RST = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        chk("midrst_sc", scancode, 0);
        chk("midrst_flag", flag, 0);
        chk("midrst_rx", rx_byte, 0);
        chk("midrst_valid", valid, 0);
        chk("midrst_err", err, 0);
        #1;
        RST = 1'b0;
        m_rx = '0; m_sc = '0; m_flag = 1'b0; m_brk = 1'b0;
        e0 = err_cnt;
        cyc(2200);
        @(negedge CLK);
        chk("midrst_no_err", err_cnt - e0, 0);
        good_frame("post_rst", 8'h4B);

        // Randomized byte stream against the model
        for (int unsigned i = 0; i < 14; i++) begin
            sel = $urandom_range(0, 4);
            case (sel)
                0: rb = 8'hE0;
                1: rb = 8'hF0;
                2: rb = m_sc;
                default: begin
                    rb = 8'($urandom_range(1, 255));
                    if (rb == 8'hE0 || rb == 8'hF0) rb = 8'h12;
                end
            endcase
            if ($urandom_range(0, 5) == 0) begin
                bad_frame("rnd_bad", rb, 1'b1, 1'b1);
            end else begin
                good_frame("rnd", rb);
            end
        end

        @(negedge CLK);
        chk("valid_err_excl", both_cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
